// File: rtl/xc_malu_mul_seq.sv
// Sequential radix-2^STEPS shift-add multiplier for RV32M mul/mulh/mulhsu/mulhu.
// Optional early exit on a zero remaining multiplier: define XC_MALU_MUL_EARLY_EXIT_EN.
module xc_malu_mul_seq #(
  parameter int STEPS = 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        valid,
  input  logic        lhs_signed,
  input  logic        rhs_signed,
  input  logic        op_high,
  input  logic        flush,
  output logic        busy,
  output logic        ready,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [63:0] acc;
  logic [5:0]  count;
  logic        sign;
  logic        hi_sel;

  logic        lhs_neg;
  logic        rhs_neg;
  logic [31:0] rs1_abs;
  logic [31:0] rs2_abs;
  logic [63:0] acc_n;
  logic [63:0] mcand_n;
  logic [31:0] mplier_n;
  logic [5:0]  count_n;
  logic [63:0] product;
  logic        run_last;

  // Magnitudes fit in 32 bits unsigned, including |-2^31| = 0x80000000.
  assign lhs_neg = lhs_signed & rs1[31];
  assign rhs_neg = rhs_signed & rs2[31];
  assign rs1_abs = lhs_neg ? -rs1 : rs1;
  assign rs2_abs = rhs_neg ? -rs2 : rs2;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    acc_n = acc;
    for (int i = 0; i < STEPS; i++) begin
      if (mplier[i]) acc_n = acc_n + (mcand << i);
    end
    mcand_n  = mcand << STEPS;
    mplier_n = mplier >> STEPS;
    count_n  = count + 6'(STEPS);
    product  = sign ? -acc_n : acc_n;
  end

`ifdef XC_MALU_MUL_EARLY_EXIT_EN
  // acc is never shifted, so once the multiplier runs out it already holds the full product.
  assign run_last = (count_n == 6'd32) || (mplier_n == '0);
`else
  assign run_last = (count_n == 6'd32);
`endif

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      // NOTE: the datapath registers are plain flops, not memories, so they are cleared with everything else.
      state  <= IDLE;
      busy   <= 1'b0;
      ready  <= 1'b0;
      result <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      sign   <= 1'b0;
      hi_sel <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (valid) begin
            state  <= RUN;
            busy   <= 1'b1;
            mcand  <= {32'h0, rs1_abs};
            mplier <= rs2_abs;
            acc    <= '0;
            count  <= '0;
            sign   <= lhs_neg ^ rhs_neg;
            hi_sel <= op_high;
          end
        end
        RUN: begin
          acc    <= acc_n;
          mcand  <= mcand_n;
          mplier <= mplier_n;
          count  <= count_n;
          if (run_last) begin
            state  <= DONE;
            ready  <= 1'b1;
            result <= hi_sel ? product[63:32] : product[31:0];
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          ready <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xc_malu_mul_seq.sv
// Self-checking bench for xc_malu_mul_seq: one STEPS=1 and one STEPS=4 instance,
// scoreboard of expected result/latency computed from a 64-bit product model.
module tb_xc_malu_mul_seq;

  logic        clock = 1'b0;
  logic        resetn;
  logic        flush;
  logic [31:0] rs1, rs2;
  logic        lhs_signed, rhs_signed, op_high;
  logic        valid1, valid4;
  logic        busy1, ready1, busy4, ready4;
  logic [31:0] result1, result4;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res1;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;

  xc_malu_mul_seq #(.STEPS(1)) u_dut1 (
    .clock(clock), .resetn(resetn), .rs1(rs1), .rs2(rs2), .valid(valid1),
    .lhs_signed(lhs_signed), .rhs_signed(rhs_signed), .op_high(op_high),
    .flush(flush), .busy(busy1), .ready(ready1), .result(result1)
  );

  xc_malu_mul_seq #(.STEPS(4)) u_dut4 (
    .clock(clock), .resetn(resetn), .rs1(rs1), .rs2(rs2), .valid(valid4),
    .lhs_signed(lhs_signed), .rhs_signed(rhs_signed), .op_high(op_high),
    .flush(flush), .busy(busy4), .ready(ready4), .result(result4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic ls, input logic rs, input logic oh,
                                 input int steps);
    exp_t        e;
    logic [63:0] x, y, p;
    logic [31:0] babs;
    int          bl;
    x = ls ? {{32{a[31]}}, a} : {32'h0, a};
    y = rs ? {{32{b[31]}}, b} : {32'h0, b};
    p = x * y;
    e.res = oh ? p[63:32] : p[31:0];
    babs = (rs && b[31]) ? -b : b;
    bl = 0;
    for (int i = 0; i < 32; i++) if (babs[i]) bl = i + 1;
`ifdef XC_MALU_MUL_EARLY_EXIT_EN
    e.lat = (bl == 0) ? 2 : (bl + steps - 1) / steps + 1;
`else
    e.lat = 32 / steps + 1;
`endif
    return e;
  endfunction

  // Issues one operation, counts edges from the accepting edge to ready, then
  // checks the single-cycle ready pulse. With hold=1, valid stays high past ready.
  task automatic do_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                       input logic ls, input logic rs, input logic oh, input bit hold);
    int          edges;
    bit          got;
    bit          bsy;
    exp_t        e;
    logic [31:0] res;
    @(negedge clock);
    rs1 = a; rs2 = b; lhs_signed = ls; rhs_signed = rs; op_high = oh;
    if (sel == 4) valid4 = 1'b1; else valid1 = 1'b1;
    sb.push_back(model(a, b, ls, rs, oh, sel));
    edges = 0;
    got   = 1'b0;
    while (!got && edges < 100) begin
      @(posedge clock);
      #1;
      edges++;
      if (edges == 1) begin
        // Operands after the start edge must be ignored.
        rs1 = $urandom; rs2 = $urandom;
        lhs_signed = 1'($urandom); rhs_signed = 1'($urandom); op_high = 1'($urandom);
      end
      got = (sel == 4) ? ready4 : ready1;
      bsy = (sel == 4) ? busy4 : busy1;
      check($sformatf("busy_during_op_edge%0d", edges), 32'(bsy), 32'd1);
    end
    check("ready_within_budget", 32'(got), 32'd1);
    e = sb.pop_front();
    if (got) begin
      if (!hold) begin
        if (sel == 4) valid4 = 1'b0; else valid1 = 1'b0;
      end
      res = (sel == 4) ? result4 : result1;
      if (sel == 1) last_res1 = e.res;
      check("result", res, e.res);
      check("latency_edges", 32'(edges), 32'(e.lat));
      @(posedge clock);
      #1;
      check("ready_one_cycle", 32'((sel == 4) ? ready4 : ready1), 32'd0);
      check("idle_after_done", 32'((sel == 4) ? busy4 : busy1), 32'd0);
    end
  endtask

  initial begin
    bit saw_ready;
    int flush_at;
    resetn = 1'b0; flush = 1'b0; valid1 = 1'b0; valid4 = 1'b0;
    rs1 = 32'hDEADBEEF; rs2 = 32'hCAFEF00D;
    lhs_signed = 1'b0; rhs_signed = 1'b0; op_high = 1'b0;
    last_res1 = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy1", 32'(busy1), 32'd0);
    check("reset_ready1", 32'(ready1), 32'd0);
    check("reset_result1", result1, 32'h0);
    check("reset_busy4", 32'(busy4), 32'd0);
    check("reset_result4", result4, 32'h0);
    resetn = 1'b1;

    // mulhu / mul unsigned extremes
    do_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    do_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    // mulh, including the most-negative operands
    do_op(1, 32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 1'b0);
    do_op(1, 32'hFFFFFFFF, 32'h00000007, 1'b1, 1'b1, 1'b0, 1'b0);
    do_op(1, 32'hFFFFFFFF, 32'h00000007, 1'b1, 1'b1, 1'b1, 1'b0);
    // mulhsu
    do_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    // small and zero multipliers (early-exit boundary when enabled)
    do_op(1, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(1, 32'h00000003, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Flush mid-run: no ready pulse, result retained.
`ifdef XC_MALU_MUL_EARLY_EXIT_EN
    flush_at = 2;
`else
    flush_at = 10;
`endif
    @(negedge clock);
    rs1 = 32'd3; rs2 = 32'd5; lhs_signed = 1'b0; rhs_signed = 1'b0; op_high = 1'b0;
    valid1 = 1'b1;
    repeat (flush_at) @(posedge clock);
    #1;
    flush = 1'b1; valid1 = 1'b0;
    @(posedge clock);
    #1;
    flush = 1'b0;
    check("flush_busy", 32'(busy1), 32'd0);
    check("flush_ready", 32'(ready1), 32'd0);
    check("flush_keeps_result", result1, last_res1);
    saw_ready = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      saw_ready |= ready1;
    end
    check("no_ready_after_flush", 32'(saw_ready), 32'd0);

    // Flush together with valid in IDLE must not start.
    @(negedge clock);
    flush = 1'b1; valid1 = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0; valid1 = 1'b0;
    check("flush_blocks_start", 32'(busy1), 32'd0);

    do_op(1, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 1'b0, 1'b0);

    // STEPS=4, valid held through ready: second op starts on the IDLE edge.
    do_op(4, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b1, 1'b1);
    do_op(4, 32'hFFFFFFFB, 32'h00000003, 1'b1, 1'b1, 1'b0, 1'b0);
    do_op(4, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
